// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled up/down/bounce/blink display.
// Optional LED_PATTERN_GRAY_OUT_EN: gray-coded leds in UP/DOWN.
module led_pattern_gen #(
  parameter int WIDTH    = 8,
  parameter int CLK_FREQ = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] leds,
  output logic             tick
);

  typedef enum logic [1:0] {
    M_UP     = 2'b00,
    M_DOWN   = 2'b01,
    M_BOUNCE = 2'b10,
    M_BLINK  = 2'b11
  } mode_e;

  localparam int BASE = (CLK_FREQ / 2 < 1) ? 1 : CLK_FREQ / 2;
  localparam int PW   = $clog2(BASE + 1);

  localparam logic [PW-1:0]    BASE_V = PW'(BASE);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL    = '1;
  localparam logic [WIDTH-1:0] TOP_M1 = ONE << (WIDTH - 2);
  localparam logic [WIDTH-1:0] BOT_P1 = ONE << 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic             dir_q, dir_d;
  mode_e            mode_q, mode_d;
  logic             tick_q, tick_d;

  logic [PW-1:0]    shifted;
  logic [PW-1:0]    lim_m1;
  logic [WIDTH-1:0] step_pat;
  logic             step_dir;
  logic [WIDTH-1:0] lsb_val;
  mode_e            mode_n;

  assign mode_n = mode_e'(mode);

  // Terminal count for the current speed; LIMIT never drops below 1.
  always_comb begin
    shifted = BASE_V >> speed;
    lim_m1  = '0;
    if (shifted != '0) begin
      lim_m1 = shifted - PW'(1);
    end
  end

  // Lowest set bit of load_val, used when loading in BOUNCE.
  always_comb begin
    lsb_val = load_val & (~load_val + ONE);
    if (load_val == '0) begin
      lsb_val = ONE;
    end
  end

  // Next pattern and direction for one display step (dir 0 = left).
  always_comb begin
    step_pat = pattern_q;
    step_dir = dir_q;
    case (mode_q)
      M_UP:   step_pat = pattern_q + ONE;
      M_DOWN: step_pat = pattern_q - ONE;
      M_BOUNCE: begin
        if (!dir_q) begin
          if (pattern_q[WIDTH-1]) begin
            step_pat = TOP_M1;
            step_dir = 1'b1;
          end else begin
            step_pat = pattern_q << 1;
          end
        end else begin
          if (pattern_q[0]) begin
            step_pat = BOT_P1;
            step_dir = 1'b0;
          end else begin
            step_pat = pattern_q >> 1;
          end
        end
      end
      M_BLINK: begin
        if (pattern_q == '0) begin
          step_pat = ALL;
        end else if (pattern_q == ALL) begin
          step_pat = '0;
        end else begin
          step_pat = ALL;
        end
      end
      default: step_pat = pattern_q;
    endcase
  end

  // Priority: load, then mode change re-init, then prescaled step.
  always_comb begin
    presc_d   = presc_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    tick_d    = 1'b0;
    mode_d    = mode_n;
    if (load) begin
      presc_d = '0;
      if (mode_n == M_BOUNCE) begin
        pattern_d = lsb_val;
      end else begin
        pattern_d = load_val;
      end
    end else if (mode_n != mode_q) begin
      presc_d = '0;
      case (mode_n)
        M_UP:     pattern_d = '0;
        M_DOWN:   pattern_d = ALL;
        M_BOUNCE: begin
          pattern_d = ONE;
          dir_d     = 1'b0;
        end
        M_BLINK:  pattern_d = '0;
        default:  pattern_d = '0;
      endcase
    end else if (enable) begin
      if (presc_q >= lim_m1) begin
        presc_d   = '0;
        tick_d    = 1'b1;
        pattern_d = step_pat;
        dir_d     = step_dir;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      pattern_q <= '0;
      dir_q     <= 1'b0;
      mode_q    <= M_UP;
      tick_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

`ifdef LED_PATTERN_GRAY_OUT_EN
  logic [WIDTH-1:0] leds_q, leds_d;

  // Gray-code the counting modes; same edge as the pattern update.
  always_comb begin
    leds_d = pattern_d;
    if (mode_n == M_UP || mode_n == M_DOWN) begin
      leds_d = pattern_d ^ (pattern_d >> 1);
    end
  end

  // Output register for the gray-coded view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_q <= '0;
    end else begin
      leds_q <= leds_d;
    end
  end

  assign leds = leds_q;
`else
  assign leds = pattern_q;
`endif

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the board LED half-second counter.
- Drives a WIDTH-bit LED bank from a programmable prescaler with four display modes: up-count, down-count, bouncing single LED, and blink-all.
- Supports enable, speed select and synchronous load.
- Sits directly between the top-level clock/reset and the board LED pins; also exports the step tick for other status logic.

Parameters:
- WIDTH, 8, LED bank width; legal range 2..32.
- CLK_FREQ, 25_000_000, clk frequency in Hz; base step period = CLK_FREQ/2 cycles (0.5 s).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = prescaler runs and pattern advances; 0 = freeze.
- mode  in  2  00 UP, 01 DOWN, 10 BOUNCE, 11 BLINK.
- speed  in  2  step period divisor: 1, 2, 4, 8.
- load  in  1  single-cycle synchronous load strobe.
- load_val  in  WIDTH  value written to the pattern on load.
- leds  out  WIDTH  registered LED pattern.
- tick  out  1  registered one-cycle pulse on every pattern step.

Behaviour:
- Reset is asynchronous active-high. While rst = 1:
  - prescaler = 0, pattern = 0, leds = 0, tick = 0.
  - dir = left, mode_q = 00 (UP).
- Step limit: LIMIT = max((CLK_FREQ/2) >> speed, 1). Recomputed combinationally from the current speed.
- Prescaler width: enough bits to hold CLK_FREQ/2.
- Prescaler, when enable = 1:
  - If prescaler >= LIMIT-1: prescaler <= 0, tick <= 1, pattern steps.
  - Else: prescaler + 1, tick <= 0.
  - The >= compare guarantees a tick on the next cycle when speed is raised mid-count.
- When enable = 0: prescaler, pattern and dir hold; tick <= 0.
- Step latency: tick and the new leds value become visible on the same clock edge.
- Step rules:
  - UP: pattern + 1, wraps all-ones -> 0.
  - DOWN: pattern - 1, wraps 0 -> all-ones.
  - BOUNCE: one-hot shift in direction dir. At bit WIDTH-1 moving left: dir flips and the bit moves to WIDTH-2. Symmetrically at bit 0 moving right: dir flips and the bit moves to bit 1. Endpoints are lit for exactly one step.
  - BLINK: pattern <= ~pattern restricted to all-ones / all-zeros; any non-uniform value goes to all-ones.
- Mode change: mode_q registers mode every cycle. When mode != mode_q:
  - pattern re-initialises: UP 0, DOWN all-ones, BOUNCE 1 with dir = left, BLINK 0.
  - prescaler <= 0, tick <= 0.
  - This happens regardless of enable.
- Load: when load = 1, pattern <= load_val, prescaler <= 0, tick <= 0.
  - In BOUNCE, the loaded value is reduced to the lowest set bit of load_val; load_val = 0 loads 1. dir is unchanged.
  - In BLINK, load_val is taken verbatim; it normalises on the next step.
- Priority (same cycle): rst > load > mode change > step.
  - A load coinciding with a mode change also updates mode_q and uses the new mode's BOUNCE reduction.
- Reset mid-operation: returns immediately to the reset state. If mode != 00 after release, the first edge performs a mode-change re-init.
- leds is a pure register output with no combinational path from inputs.

Optional Feature:
- Macro: LED_PATTERN_GRAY_OUT_EN.
- Defined: in UP and DOWN modes, leds <= gray(next pattern) = p ^ (p >> 1). The gray register updates on the same edge as the pattern, so there is no extra latency. BOUNCE and BLINK are unaffected. The internal pattern stays binary, and load_val is interpreted as binary.
- Undefined: leds equals the pattern in all modes. No gray logic is synthesised.

Test Plan (CLK_FREQ = 8, so the base LIMIT is 4; WIDTH = 4):
- Assert rst async mid-cycle, release; mode 00, speed 0, enable 1 -> leds 0 while rst; tick every 4th cycle; leds steps 0,1,2,...,F,0 (wrap verified).
- mode switched 00->01 with leds = 5 -> next edge leds = F and prescaler cleared; then ticks every 4 cycles giving E, D, ...; 0 wraps to F.
- mode 10 -> leds 1,2,4,8,4,2,1,2; speed 2 gives LIMIT 1 (tick every cycle); speed 3 is clamped to 1.
- load = 1 with load_val = 6 in BOUNCE -> leds = 2; the same in UP -> leds = 6. Load asserted in the same cycle as a mode change 00->11 -> leds = load_val, no tick.
- enable = 0 for 10 cycles mid-count -> leds and tick frozen; after re-enable, the remaining prescaler count is honoured (no lost or extra step). Raising speed 0->2 at prescaler = 3 -> tick on the next cycle.
- With LED_PATTERN_GRAY_OUT_EN, UP mode -> leds 0,1,3,2,6,7,5,4,C; BOUNCE output is identical to the build without the macro.
